// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: time-multiplexes a 6-digit packed BCD value onto a
// 6-digit 7-segment display. The value is double-buffered so it only changes
// on a frame boundary. The block can blank leading zeros and flags non-decimal
// nibbles with a sticky err bit.
module bcd_seg_scanner #(
    parameter int SCAN_DIV   = 50000,
    parameter bit SEG_ACT_LO = 1'b1,
    parameter bit AN_ACT_LO  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [5:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  an,
    output logic        err
);

    localparam int            PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [6:0]    SEG_OFF   = SEG_ACT_LO ? 7'h7F : 7'h00;
    localparam logic          DP_OFF    = SEG_ACT_LO;
    localparam logic [5:0]    AN_OFF    = AN_ACT_LO ? 6'h3F : 6'h00;

    // Scan timing and buffering state
    logic [PW-1:0] presc_reg, presc_next;
    logic [2:0]    idx_reg, idx_next;
    logic [23:0]   active_reg, active_next;
    logic [23:0]   pending_reg, pending_next;
    logic          pend_v_reg, pend_v_next;
    logic          err_reg, err_next;

    // Registered pin drivers
    logic [6:0]    seg_reg, seg_next;
    logic          dp_reg, dp_next;
    logic [5:0]    an_reg, an_next;

    logic          tick;
    logic          frame_end;

    // Per-digit views of the displayed value
    logic [3:0]    digit [6];
    logic [5:0]    upper_zero;
    logic [5:0]    slot_hot;

    // Currently scanned digit and its decode
    logic [3:0]    cur_nib;
    logic          cur_upper_zero;
    logic          cur_dp;
    logic          blank;
    logic          nib_bad;
    logic [6:0]    seg_hi;

    assign tick      = (presc_reg == PRESC_MAX);
    assign frame_end = tick && (idx_reg == 3'd5);

    // upper_zero[i] is set when digits i..5 are all zero: those slots are
    // candidates for leading-zero blanking.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            assign digit[gi]      = active_reg[4*gi +: 4];
            assign upper_zero[gi] = (active_reg[23:4*gi] == '0);
            assign slot_hot[gi]   = (idx_reg == 3'(gi));
        end
    endgenerate

    // Select the digit, blanking flag and decimal point for the current slot
    always_comb begin
        cur_nib        = 4'h0;
        cur_upper_zero = 1'b0;
        cur_dp         = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (slot_hot[i]) begin
                cur_nib        = digit[i];
                cur_upper_zero = upper_zero[i];
                cur_dp         = dp_mask[i];
            end
        end
        // Digit 0 always shows, so a zero value still displays a single "0"
        blank = blank_lz && !slot_hot[0] && cur_upper_zero;
    end

    // Active-high segment decode; non-decimal nibbles show a dash
    always_comb begin
        seg_hi  = 7'h40;
        nib_bad = 1'b0;
        case (cur_nib)
            4'd0:    seg_hi = 7'h3F;
            4'd1:    seg_hi = 7'h06;
            4'd2:    seg_hi = 7'h5B;
            4'd3:    seg_hi = 7'h4F;
            4'd4:    seg_hi = 7'h66;
            4'd5:    seg_hi = 7'h6D;
            4'd6:    seg_hi = 7'h7D;
            4'd7:    seg_hi = 7'h07;
            4'd8:    seg_hi = 7'h7F;
            4'd9:    seg_hi = 7'h6F;
            default: begin
                seg_hi  = 7'h40;
                nib_bad = 1'b1;
            end
        endcase
    end

    // Next-state for prescaler, slot index, double buffer and error flag
    always_comb begin
        presc_next   = tick ? '0 : presc_reg + PW'(1);
        idx_next     = idx_reg;
        if (tick) begin
            idx_next = (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
        end
        // A load coincident with the frame boundary leaves the new value
        // pending: the boundary still copies the old pending contents.
        pending_next = load ? bcd_in : pending_reg;
        active_next  = (frame_end && pend_v_reg) ? pending_reg : active_reg;
        pend_v_next  = pend_v_reg;
        if (load) begin
            pend_v_next = 1'b1;
        end else if (frame_end) begin
            pend_v_next = 1'b0;
        end
        // A new load always wins over a same-cycle error set
        err_next = err_reg;
        if (load) begin
            err_next = 1'b0;
        end else if (nib_bad) begin
            err_next = 1'b1;
        end
    end

    // Pin values for the current slot, polarity applied
    always_comb begin
        seg_next = SEG_ACT_LO ? ~seg_hi : seg_hi;
        dp_next  = cur_dp ? ~DP_OFF : DP_OFF;
        an_next  = AN_ACT_LO ? ~slot_hot : slot_hot;
        if (blank) begin
            seg_next = SEG_OFF;
            dp_next  = DP_OFF;
            an_next  = AN_OFF;
        end
    end

    // Scan and buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg   <= '0;
            idx_reg     <= 3'd0;
            active_reg  <= 24'h0;
            pending_reg <= 24'h0;
            pend_v_reg  <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            presc_reg   <= presc_next;
            idx_reg     <= idx_next;
            active_reg  <= active_next;
            pending_reg <= pending_next;
            pend_v_reg  <= pend_v_next;
            err_reg     <= err_next;
        end
    end

    // Output registers: one cycle behind the slot index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg <= SEG_OFF;
            dp_reg  <= DP_OFF;
            an_reg  <= AN_OFF;
        end else begin
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            an_reg  <= an_next;
        end
    end

    assign seg = seg_reg;
    assign dp  = dp_reg;
    assign an  = an_reg;
    assign err = err_reg;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Testbench for bcd_seg_scanner (SCAN_DIV=4, active-low seg and an).
// The stimulus process pushes the expected pin state for future cycles into
// a queue; the monitor pops and compares entries on the falling edge.
module tb_bcd_seg_scanner;

    localparam int DIV   = 4;
    localparam int FRAME = 6 * DIV;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [23:0] bcd_in   = 24'h0;
    logic        load     = 1'b0;
    logic        blank_lz = 1'b1;
    logic [5:0]  dp_mask  = 6'h00;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  an;
    logic        err;

    bcd_seg_scanner #(
        .SCAN_DIV   (DIV),
        .SEG_ACT_LO (1'b1),
        .AN_ACT_LO  (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bcd_in   (bcd_in),
        .load     (load),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Rising-edge counter; at a falling edge it equals the edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;
    int rel0   = 0;

    typedef struct {
        int         cyc;
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       err;
    } exp_t;

    exp_t q[$];

    // Hand table of active-high segment patterns
    function automatic logic [6:0] seg_hi(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic int base(input int f);
        return rel0 + FRAME * f;
    endfunction

    // Slot i of frame f is on the pins after edges base(f)+4i+1 .. +4
    task automatic push_slot(input int f, input int i, input int offs,
                             input logic [23:0] val, input logic blz,
                             input logic [5:0] dpm, input logic e);
        exp_t       r;
        logic [3:0] nib;
        logic       blank;
        nib     = val[4*i +: 4];
        blank   = blz && (i != 0) && ((val >> (4*i)) == 24'h0);
        r.cyc   = base(f) + DIV * i + offs;
        r.an    = blank ? 6'h3F : ~(6'b000001 << i);
        r.seg   = blank ? 7'h7F : ~seg_hi(nib);
        r.dp    = blank ? 1'b1 : ~dpm[i];
        r.err   = e;
        q.push_back(r);
    endtask

    task automatic push_frame(input int f, input int ns, input logic [23:0] val,
                              input logic blz, input logic [5:0] dpm,
                              input logic [5:0] errv);
        for (int i = 0; i < ns; i++) begin
            push_slot(f, i, 2, val, blz, dpm, errv[i]);
            push_slot(f, i, 4, val, blz, dpm, errv[i]);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Strobe load so the value is captured on rising edge e
    task automatic load_at(input int e, input logic [23:0] val);
        goto(e - 1);
        load   = 1'b1;
        bcd_in = val;
        goto(e);
        load   = 1'b0;
    endtask

    task automatic check_now(input string name, input logic [14:0] req);
        n_vec++;
        if ({an, seg, dp, err} !== req) begin
            n_miss++;
            $display("FAIL %s: an=%b seg=%h dp=%b err=%b, required an=%b seg=%h dp=%b err=%b",
                     name, an, seg, dp, err, req[14:9], req[8:2], req[1], req[0]);
        end
    endtask

    // Monitor: compare every queued expectation whose cycle has arrived
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t r;
            r = q.pop_front();
            n_vec++;
            if (r.cyc != cyc) begin
                n_miss++;
                $display("FAIL sched: entry for cycle %0d reached at cycle %0d", r.cyc, cyc);
            end else if ({an, seg, dp, err} !== {r.an, r.seg, r.dp, r.err}) begin
                n_miss++;
                $display("FAIL slot@%0d: an=%b seg=%h dp=%b err=%b, required an=%b seg=%h dp=%b err=%b",
                         cyc - rel0, an, seg, dp, err, r.an, r.seg, r.dp, r.err);
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        @(negedge clk);
        @(negedge clk);
        check_now("reset_hold", {6'h3F, 7'h7F, 1'b1, 1'b0});
        rst_n = 1'b1;
        rel0  = cyc;

        // Reset value 0 with blanking: only slot 0 lit
        push_frame(0, 6, 24'h000000, 1'b1, 6'h00, 6'h00);
        goto(base(1));
        push_frame(1, 6, 24'h000000, 1'b1, 6'h00, 6'h00);
        // Mid-frame load must not show until the next frame
        load_at(base(1) + 6, 24'h123456);

        goto(base(2));
        dp_mask = 6'b000100;
        push_frame(2, 6, 24'h123456, 1'b1, 6'b000100, 6'h00);

        goto(base(3));
        push_frame(3, 6, 24'h123456, 1'b1, 6'b000100, 6'h00);
        load_at(base(3) + 10, 24'h000042);

        // Leading zeros blanked, dp suppressed on blanked slot 2
        goto(base(4));
        push_frame(4, 6, 24'h000042, 1'b1, 6'b000100, 6'h00);

        // blank_lz taken live: zeros now shown
        goto(base(5));
        blank_lz = 1'b0;
        push_frame(5, 6, 24'h000042, 1'b0, 6'b000100, 6'h00);
        load_at(base(5) + 10, 24'h0A0000);

        // Dash on slot 4 sets err
        goto(base(6));
        blank_lz = 1'b1;
        dp_mask  = 6'h00;
        push_frame(6, 6, 24'h0A0000, 1'b1, 6'h00, 6'b110000);

        // Load on the same edge that re-decodes the bad nibble: load wins,
        // then err sets again on the following cycle while A is still shown
        goto(base(7));
        push_frame(7, 4, 24'h0A0000, 1'b1, 6'h00, 6'b001111);
        push_slot(7, 4, 1, 24'h0A0000, 1'b1, 6'h00, 1'b0);
        push_slot(7, 4, 2, 24'h0A0000, 1'b1, 6'h00, 1'b1);
        push_slot(7, 4, 4, 24'h0A0000, 1'b1, 6'h00, 1'b1);
        push_slot(7, 5, 2, 24'h0A0000, 1'b1, 6'h00, 1'b1);
        push_slot(7, 5, 4, 24'h0A0000, 1'b1, 6'h00, 1'b1);
        load_at(base(7) + 17, 24'h000001);

        // err sticky until the load at +10 clears it
        goto(base(8));
        push_frame(8, 6, 24'h000001, 1'b1, 6'h00, 6'b000011);
        load_at(base(8) + 10, 24'h000077);

        // Load coincident with the frame boundary
        load_at(base(9), 24'h00C0B5);
        push_frame(9, 6, 24'h000077, 1'b1, 6'h00, 6'h00);

        goto(base(10));
        push_frame(10, 3, 24'h00C0B5, 1'b1, 6'h00, 6'b000010);
        push_slot(10, 3, 2, 24'h00C0B5, 1'b1, 6'h00, 1'b1);
        // This pending value must be discarded by the reset below
        load_at(base(10) + 10, 24'h999999);

        // Asynchronous reset in the middle of slot 3 (err is 1 here)
        goto(base(10) + 14);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", {6'h3F, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        @(negedge clk);
        check_now("reset_held", {6'h3F, 7'h7F, 1'b1, 1'b0});
        rst_n = 1'b1;
        rel0  = cyc;
        push_frame(0, 6, 24'h000000, 1'b1, 6'h00, 6'h00);
        push_frame(1, 6, 24'h000000, 1'b1, 6'h00, 6'h00);
        goto(base(2));

        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
